// File: rtl/ps2_pkg.sv
// ============================================================================
// Module   : ps2_pkg
// Brief    : Shared PS/2 host transmitter types, error codes and parity helper.
// Revision : 1.0
// ============================================================================
`default_nettype none

package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_INHIBIT    = 3'd1,
        ST_RTS        = 3'd2,
        ST_WAIT_FIRST = 3'd3,
        ST_SHIFT      = 3'd4,
        ST_ACK        = 3'd5,
        ST_RELEASE    = 3'd6
    } ps2_state_e;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_START = 2'b01;
    localparam logic [1:0] ERR_BIT   = 2'b10;
    localparam logic [1:0] ERR_NOACK = 2'b11;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_host_tx_if.sv
// ============================================================================
// Module   : ps2_host_tx_if
// Brief    : Command-byte handshake and completion status of the PS/2 host TX.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface ps2_host_tx_if;

    logic [7:0] i_data;
    logic       i_valid;
    logic       o_ready;
    logic       o_done;
    logic       o_err;
    logic [1:0] o_err_code;

    modport master (
        output i_data,
        output i_valid,
        input  o_ready,
        input  o_done,
        input  o_err,
        input  o_err_code
    );

    modport slave (
        input  i_data,
        input  i_valid,
        output o_ready,
        output o_done,
        output o_err,
        output o_err_code
    );

endinterface

`default_nettype wire

// File: rtl/ps2_line_sync.sv
// ============================================================================
// Module   : ps2_line_sync
// Brief    : 2-FF pin synchronizer with falling-edge detect for one PS/2 line.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ps2_line_sync (
    input  wire logic i_clk_100k,
    input  wire logic i_rst_n,
    input  wire logic i_pin,
    output logic      o_level,
    output logic      o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // Reset to the idle (pulled-up) level so leaving reset never looks like a fall.
    always_ff @(posedge i_clk_100k or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
            r_prev <= 1'b1;
        end else begin
            r_meta <= i_pin;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_level = r_sync;
    assign o_fall  = r_prev & ~r_sync;

endmodule

`default_nettype wire

// File: rtl/ps2_host_tx.sv
// ============================================================================
// Module   : ps2_host_tx
// Brief    : PS/2 host-to-device command transmitter with device ACK check.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 12,
    parameter int START_TIMEOUT  = 1500,
    parameter int BIT_TIMEOUT    = 200
) (
    input  wire logic     i_clk_100k,
    input  wire logic     i_rst_n,
    ps2_host_tx_if.slave  host,
    input  wire logic     i_ps2_clk,
    input  wire logic     i_ps2_dat,
    output logic          o_ps2_clk_oe,
    output logic          o_ps2_dat_oe
);

    localparam int CNT_W = 16;

    ps2_state_e       r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [3:0]       r_bidx, w_bidx_nxt;
    logic [9:0]       r_frame, w_frame_nxt;
    logic             r_clk_oe, w_clk_oe_nxt;
    logic             r_dat_oe, w_dat_oe_nxt;
    logic             r_done, w_done_nxt;
    logic             r_err, w_err_nxt;
    logic [1:0]       r_code, w_code_nxt;
    logic             w_abort;
    logic [1:0]       w_abort_code;
    logic             w_ready;
    logic             w_clk_lvl, w_clk_fall;
    logic             w_dat_lvl, w_dat_fall_unused;

    ps2_line_sync u_sync_clk (
        .i_clk_100k (i_clk_100k),
        .i_rst_n    (i_rst_n),
        .i_pin      (i_ps2_clk),
        .o_level    (w_clk_lvl),
        .o_fall     (w_clk_fall)
    );

    ps2_line_sync u_sync_dat (
        .i_clk_100k (i_clk_100k),
        .i_rst_n    (i_rst_n),
        .i_pin      (i_ps2_dat),
        .o_level    (w_dat_lvl),
        .o_fall     (w_dat_fall_unused)
    );

    // Ready drops during the done/err pulse so the pulse cycle is never an accept cycle.
    assign w_ready = (r_state == ST_IDLE) && !r_done && !r_err;

    always_ff @(posedge i_clk_100k or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_bidx   <= '0;
            r_frame  <= '0;
            r_clk_oe <= 1'b0;
            r_dat_oe <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_code   <= ERR_NONE;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_bidx   <= w_bidx_nxt;
            r_frame  <= w_frame_nxt;
            r_clk_oe <= w_clk_oe_nxt;
            r_dat_oe <= w_dat_oe_nxt;
            r_done   <= w_done_nxt;
            r_err    <= w_err_nxt;
            r_code   <= w_code_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt + CNT_W'(1);
        w_bidx_nxt   = r_bidx;
        w_frame_nxt  = r_frame;
        w_clk_oe_nxt = r_clk_oe;
        w_dat_oe_nxt = r_dat_oe;
        w_done_nxt   = 1'b0;
        w_err_nxt    = 1'b0;
        w_code_nxt   = r_code;
        w_abort      = 1'b0;
        w_abort_code = ERR_NONE;

        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt    = '0;
                w_clk_oe_nxt = 1'b0;
                w_dat_oe_nxt = 1'b0;
                if (w_ready && host.i_valid) begin
                    w_frame_nxt  = {1'b1, odd_parity(host.i_data), host.i_data};
                    w_code_nxt   = ERR_NONE;
                    w_bidx_nxt   = '0;
                    w_clk_oe_nxt = 1'b1;
                    w_state_nxt  = ST_INHIBIT;
                end
            end
            ST_INHIBIT: begin
                if (r_cnt == CNT_W'(INHIBIT_CYCLES - 1)) begin
                    w_dat_oe_nxt = 1'b1;
                    w_state_nxt  = ST_RTS;
                end
            end
            ST_RTS: begin
                w_clk_oe_nxt = 1'b0;
                w_cnt_nxt    = '0;
                w_state_nxt  = ST_WAIT_FIRST;
            end
            ST_WAIT_FIRST: begin
                if (w_clk_fall) begin
                    w_dat_oe_nxt = ~r_frame[0];
                    w_bidx_nxt   = 4'd1;
                    w_cnt_nxt    = '0;
                    w_state_nxt  = ST_SHIFT;
                end else if (r_cnt == CNT_W'(START_TIMEOUT - 1)) begin
                    w_abort      = 1'b1;
                    w_abort_code = ERR_START;
                end
            end
            ST_SHIFT: begin
                if (w_clk_fall) begin
                    w_dat_oe_nxt = ~r_frame[r_bidx];
                    w_bidx_nxt   = r_bidx + 4'd1;
                    w_cnt_nxt    = '0;
                    if (r_bidx == 4'd9) begin
                        w_state_nxt = ST_ACK;
                    end
                end else if (r_cnt == CNT_W'(BIT_TIMEOUT - 1)) begin
                    w_abort      = 1'b1;
                    w_abort_code = ERR_BIT;
                end
            end
            ST_ACK: begin
                w_dat_oe_nxt = 1'b0;
                if (w_clk_fall) begin
                    if (!w_dat_lvl) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_RELEASE;
                    end else begin
                        w_abort      = 1'b1;
                        w_abort_code = ERR_NOACK;
                    end
                end else if (r_cnt == CNT_W'(BIT_TIMEOUT - 1)) begin
                    w_abort      = 1'b1;
                    w_abort_code = ERR_BIT;
                end
            end
            ST_RELEASE: begin
                if (w_clk_lvl && w_dat_lvl) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt == CNT_W'(BIT_TIMEOUT - 1)) begin
                    w_abort      = 1'b1;
                    w_abort_code = ERR_BIT;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Every abort path frees both lines and reports through the same pulse.
        if (w_abort) begin
            w_clk_oe_nxt = 1'b0;
            w_dat_oe_nxt = 1'b0;
            w_err_nxt    = 1'b1;
            w_code_nxt   = w_abort_code;
            w_state_nxt  = ST_IDLE;
        end
    end

    assign host.o_ready      = w_ready;
    assign host.o_done       = r_done;
    assign host.o_err        = r_err;
    assign host.o_err_code   = r_code;
    assign o_ps2_clk_oe      = r_clk_oe;
    assign o_ps2_dat_oe      = r_dat_oe;

endmodule

`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
// ============================================================================
// Module   : tb_ps2_host_tx
// Brief    : Directed bench for ps2_host_tx with a PS/2 device model and scoreboards.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ps2_host_tx;
    import ps2_pkg::*;

    typedef struct packed {
        logic       done;
        logic       err;
        logic [1:0] code;
    } res_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic dev_clk = 1'b1;
    logic dev_dat = 1'b1;
    logic clk_oe;
    logic dat_oe;
    logic ps2_clk_pin;
    logic ps2_dat_pin;

    int   n_checks = 0;
    int   n_errors = 0;
    logic bit_q[$];
    res_t exp_q[$];
    res_t obs_q[$];

    always #5 clk = ~clk;

    // Open-drain wired-AND of host and device on each line.
    assign ps2_clk_pin = ~clk_oe & dev_clk;
    assign ps2_dat_pin = ~dat_oe & dev_dat;

    ps2_host_tx_if bus ();

    ps2_host_tx dut (
        .i_clk_100k   (clk),
        .i_rst_n      (rst_n),
        .host         (bus.slave),
        .i_ps2_clk    (ps2_clk_pin),
        .i_ps2_dat    (ps2_dat_pin),
        .o_ps2_clk_oe (clk_oe),
        .o_ps2_dat_oe (dat_oe)
    );

    always @(negedge clk) begin
        if (bus.o_done || bus.o_err) begin
            obs_q.push_back({bus.o_done, bus.o_err, bus.o_err_code});
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit track);
        int t = 0;
        while (!bus.o_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t == 100) check("ready_wait", 32'(bus.o_ready), 32'd1);
        bus.i_data  = b;
        bus.i_valid = 1'b1;
        @(negedge clk);
        bus.i_valid = 1'b0;
        if (track) begin
            bit_q.push_back(1'b0);
            for (int i = 0; i < 8; i++) bit_q.push_back(b[i]);
            bit_q.push_back(~^b);
            bit_q.push_back(1'b1);
        end
    endtask

    task automatic sample_bit(input string tag);
        logic e;
        e = (bit_q.size() > 0) ? bit_q.pop_front() : 1'bx;
        check(tag, 32'(ps2_dat_pin), 32'(e));
    endtask

    task automatic dev_wait_release(input bit chk);
        int t = 0;
        while (clk_oe && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t == 100) check("release_wait", 32'(clk_oe), 32'd0);
        if (chk) sample_bit("start_bit");
        repeat (4) @(negedge clk);
    endtask

    task automatic dev_pulse(input bit chk);
        dev_clk = 1'b0;
        repeat (4) @(negedge clk);
        dev_clk = 1'b1;
        if (chk) sample_bit("frame_bit");
        repeat (4) @(negedge clk);
    endtask

    task automatic dev_frame_and_ack();
        repeat (10) dev_pulse(1'b1);
        dev_dat = 1'b0;
        dev_pulse(1'b0);
        repeat (2) @(negedge clk);
        dev_dat = 1'b1;
    endtask

    task automatic get_result(input string tag);
        int   t = 0;
        res_t e;
        res_t o;
        while (obs_q.size() == 0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        e = exp_q.pop_front();
        o = (obs_q.size() > 0) ? obs_q.pop_front() : 4'b1111;
        check(tag, {28'd0, o}, {28'd0, e});
    endtask

    initial begin
        int n;
        int dat_first;
        int seen;

        bus.i_data  = 8'h00;
        bus.i_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready",    32'(bus.o_ready),    32'd1);
        check("rst_done",     32'(bus.o_done),     32'd0);
        check("rst_err",      32'(bus.o_err),      32'd0);
        check("rst_err_code", 32'(bus.o_err_code), 32'(ERR_NONE));
        check("rst_clk_oe",   32'(clk_oe),         32'd0);
        check("rst_dat_oe",   32'(dat_oe),         32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 0xED with ACK; frame bits checked by the device model
        exp_q.push_back({1'b1, 1'b0, ERR_NONE});
        send_byte(8'hED, 1'b1);
        dev_wait_release(1'b1);
        dev_frame_and_ack();
        get_result("ed_result");
        check("ed_bits_left", 32'(bit_q.size()), 32'd0);
        repeat (20) @(negedge clk);
        check("ed_single_pulse", 32'(obs_q.size()), 32'd0);
        check("ed_ready", 32'(bus.o_ready), 32'd1);

        // 0xF4: inhibit length and RTS overlap
        exp_q.push_back({1'b1, 1'b0, ERR_NONE});
        send_byte(8'hF4, 1'b1);
        n = 0;
        dat_first = -1;
        while (clk_oe && n < 100) begin
            n++;
            if (dat_oe && dat_first < 0) dat_first = n;
            @(negedge clk);
        end
        check("f4_clk_oe_cycles", 32'(n), 32'd13);
        check("f4_dat_oe_rise", 32'(dat_first), 32'd13);
        dev_wait_release(1'b1);
        dev_frame_and_ack();
        get_result("f4_result");

        // no device clock: start timeout
        exp_q.push_back({1'b0, 1'b1, ERR_START});
        send_byte(8'hFF, 1'b0);
        n = 0;
        while (clk_oe && n < 100) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (!bus.o_err && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("start_timeout_cycles", 32'(n), 32'd1500);
        check("start_to_clk_oe", 32'(clk_oe), 32'd0);
        check("start_to_dat_oe", 32'(dat_oe), 32'd0);
        get_result("start_to_result");
        repeat (5) @(negedge clk);
        check("err_code_held", 32'(bus.o_err_code), 32'(ERR_START));

        // all edges clocked but DATA left high: no ACK
        exp_q.push_back({1'b0, 1'b1, ERR_NOACK});
        send_byte(8'h55, 1'b1);
        check("err_code_cleared", 32'(bus.o_err_code), 32'(ERR_NONE));
        dev_wait_release(1'b1);
        repeat (10) dev_pulse(1'b1);
        dev_pulse(1'b0);
        get_result("noack_result");
        repeat (5) @(negedge clk);
        check("noack_no_done", 32'(obs_q.size()), 32'd0);

        // device stops after its 4th falling edge
        exp_q.push_back({1'b0, 1'b1, ERR_BIT});
        send_byte(8'h12, 1'b0);
        dev_wait_release(1'b0);
        repeat (3) dev_pulse(1'b0);
        dev_clk = 1'b0;
        n = 0;
        while (!bus.o_err && n < 400) begin
            @(negedge clk);
            n++;
            if (n == 4) dev_clk = 1'b1;
        end
        check("bit_timeout_cycles", 32'(n), 32'd203);
        get_result("bit_to_result");

        // asynchronous reset while in SHIFT with DATA driven low
        send_byte(8'h3A, 1'b0);
        dev_wait_release(1'b0);
        repeat (3) dev_pulse(1'b0);
        dev_clk = 1'b0;
        repeat (2) @(negedge clk);
        check("pre_reset_dat_oe", 32'(dat_oe), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_clk_oe", 32'(clk_oe), 32'd0);
        check("reset_dat_oe", 32'(dat_oe), 32'd0);
        dev_clk = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("post_reset_ready", 32'(bus.o_ready), 32'd1);
        check("post_reset_no_pulse", 32'(obs_q.size()), 32'd0);

        // 0x00 offered while busy must be ignored
        exp_q.push_back({1'b1, 1'b0, ERR_NONE});
        send_byte(8'hA5, 1'b1);
        repeat (3) @(negedge clk);
        bus.i_data  = 8'h00;
        bus.i_valid = 1'b1;
        @(negedge clk);
        bus.i_valid = 1'b0;
        dev_wait_release(1'b1);
        dev_frame_and_ack();
        get_result("busy_a5_result");
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (clk_oe) seen++;
        end
        check("busy_no_second_tx", 32'(seen), 32'd0);
        check("busy_bits_left", 32'(bit_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
